// File: rtl/sb_rx_deframer_if.sv
// Sideband receive deframer port bundle.
// Serial line in, decoded byte stream and frame markers out.
interface sb_rx_deframer_if;
  logic       sbrx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    input  sbrx,
    output rx_data,
    output rx_valid,
    output rx_sof,
    output rx_eof,
    output rx_err,
    output err_code,
    output busy
  );

  modport slave (
    output sbrx,
    input  rx_data,
    input  rx_valid,
    input  rx_sof,
    input  rx_eof,
    input  rx_err,
    input  err_code,
    input  busy
  );
endinterface

// File: rtl/sb_rx_deframer.sv
// USB4 sideband receive deframer: UART symbol recovery,
// DLE/ETX framing removal and DLE unstuffing.
module sb_rx_deframer #(
  parameter int MAX_LEN      = 32,
  parameter int TIMEOUT_BITS = 64
) (
  input logic              sb_clk,
  input logic              rst,
  sb_rx_deframer_if.master sb
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [7:0] DLE = 8'hFE;
  localparam logic [7:0] ETX = 8'h40;
  localparam logic [CW-1:0] CMAX = CW'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_BITS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_BITS);

  typedef enum logic [1:0] {
    B_IDLE, B_DATA, B_STOP, B_WAIT
  } bit_st_t;

  typedef enum logic [1:0] {
    HUNT, HDR, PAYLOAD, ESC
  } byte_st_t;

  logic          s1, s2;
  bit_st_t       bit_q, bit_d;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic [7:0]    sym;
  logic          sym_vld, sym_ferr;
  byte_st_t      byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q;
  logic          start, to_run, tmo, perr;
  logic [7:0]    data_d;
  logic          vld_d, sof_d, eof_d, err_d;
  logic [1:0]    code_d;

  // two-flop synchronizer, idles high like the line
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= sb.sbrx;
      s2 <= s1;
    end
  end

  // bit layer state register
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) bit_q <= B_IDLE;
    else     bit_q <= bit_d;
  end

  // bit layer next state: start, 8 data, stop, wait-high
  always_comb begin
    bit_d = bit_q;
    unique case (bit_q)
      B_IDLE: if (!s2) bit_d = B_DATA;
      B_DATA: if (bcnt == 3'd7) bit_d = B_STOP;
      B_STOP: bit_d = s2 ? B_IDLE : B_WAIT;
      B_WAIT: if (s2) bit_d = B_IDLE;
    endcase
  end

  // bit layer datapath: LSB-first shift, symbol hand-off
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      bcnt     <= 3'd0;
      shreg    <= 8'h00;
      sym      <= 8'h00;
      sym_vld  <= 1'b0;
      sym_ferr <= 1'b0;
    end else begin
      sym_vld  <= 1'b0;
      sym_ferr <= 1'b0;
      unique case (bit_q)
        B_DATA: begin
          shreg <= {s2, shreg[7:1]};
          bcnt  <= bcnt + 3'd1;
        end
        B_STOP: begin
          sym      <= shreg;
          sym_vld  <= s2;
          sym_ferr <= ~s2;
        end
        default: bcnt <= 3'd0;
      endcase
    end
  end

  assign start  = (bit_q == B_IDLE) && !s2;
  assign to_run = (byte_q != HUNT) && (bit_q == B_IDLE) && s2;
  assign tmo    = to_run && (to_q == TLAST);

  // inter-symbol idle counter, saturating
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst)
      to_q <= '0;
    else if (start || byte_q == HUNT)
      to_q <= '0;
    else if (to_run && to_q != TMAX)
      to_q <= to_q + TW'(1);
  end

  // byte layer next state and output decode
  always_comb begin
    byte_d = byte_q;
    cnt_d  = cnt_q;
    data_d = sb.rx_data;
    vld_d  = 1'b0;
    sof_d  = 1'b0;
    eof_d  = 1'b0;
    err_d  = 1'b0;
    code_d = 2'd0;
    perr   = 1'b0;
    if (sym_vld) begin
      unique case (byte_q)
        HUNT: if (sym == DLE) byte_d = HDR;
        HDR: begin
          if (sym != DLE && sym != ETX) begin
            vld_d  = 1'b1;
            sof_d  = 1'b1;
            data_d = sym;
            cnt_d  = '0;
            byte_d = PAYLOAD;
          end else begin
            perr = 1'b1;
          end
        end
        PAYLOAD: begin
          if (sym == DLE) begin
            byte_d = ESC;
          end else if (cnt_q == CMAX) begin
            perr = 1'b1;
          end else begin
            vld_d  = 1'b1;
            data_d = sym;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        ESC: begin
          if (sym == ETX) begin
            eof_d  = 1'b1;
            byte_d = HUNT;
          end else if (sym == DLE && cnt_q != CMAX) begin
            vld_d  = 1'b1;
            data_d = DLE;
            cnt_d  = cnt_q + CW'(1);
            byte_d = PAYLOAD;
          end else begin
            perr = 1'b1;
          end
        end
      endcase
    end
    if (sym_ferr || perr || tmo) begin
      byte_d = HUNT;
      vld_d  = 1'b0;
      sof_d  = 1'b0;
      eof_d  = 1'b0;
      err_d  = 1'b1;
      data_d = sb.rx_data;
      if (sym_ferr)  code_d = 2'd1;
      else if (perr) code_d = 2'd2;
      else           code_d = 2'd3;
    end
  end

  // byte layer state, count and registered outputs
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      byte_q      <= HUNT;
      cnt_q       <= '0;
      sb.rx_data  <= 8'h00;
      sb.rx_valid <= 1'b0;
      sb.rx_sof   <= 1'b0;
      sb.rx_eof   <= 1'b0;
      sb.rx_err   <= 1'b0;
      sb.err_code <= 2'd0;
      sb.busy     <= 1'b0;
    end else begin
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      sb.rx_data  <= data_d;
      sb.rx_valid <= vld_d;
      sb.rx_sof   <= sof_d;
      sb.rx_eof   <= eof_d;
      sb.rx_err   <= err_d;
      sb.err_code <= code_d;
      sb.busy     <= (byte_d != HUNT);
    end
  end
endmodule
